// File: rtl/vram_arb_pkg.sv
// ============================================================================
// Module   : vram_arb_pkg
// Brief    : Shared types and constants for the video RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned STARVE_W   = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage : vram_arb_pkg

`default_nettype wire

// File: rtl/vram_arb_starve.sv
// ============================================================================
// Module   : vram_arb_starve
// Brief    : CPU wait counter with saturation and force-grant compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arb_starve
    import vram_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_cpu_req,
    input  logic i_cpu_gnt,
    output logic o_force
);

    localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_cpu_wait;

    // With arbitration disabled the count is frozen so a pause does not
    // erase the CPU's accumulated waiting time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_wait <= '0;
        end else if (i_enable) begin
            if (i_cpu_gnt || !i_cpu_req) begin
                r_cpu_wait <= '0;
            end else if (r_cpu_wait != c_starve_max) begin
                r_cpu_wait <= r_cpu_wait + 1'b1;
            end
        end
    end

    assign o_force = (r_cpu_wait == c_starve_max);

endmodule : vram_arb_starve

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM arbiter, VGA priority, CPU starvation guard
//            enabled by defining VRAM_ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              ext_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              w_force;
    logic              w_vga_gnt;
    logic              w_cpu_gnt;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    owner_t            r_own_s1;
    logic              r_vga_rvalid;
    logic              r_cpu_rvalid;
    logic [DATA_W-1:0] r_vga_rdata;
    logic [DATA_W-1:0] r_cpu_rdata;

`ifdef VRAM_ARB_STARVE_EN
    vram_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (ext_clk),
        .rst       (reset),
        .i_enable  (enable),
        .i_cpu_req (cpu_req),
        .i_cpu_gnt (w_cpu_gnt),
        .o_force   (w_force)
    );
`else
    // Strict VGA priority; STARVE_MAX has no effect in this build.
    assign w_force = 1'b0 & (STARVE_MAX == 0);
`endif

    always_comb begin
        w_vga_gnt = 1'b0;
        w_cpu_gnt = 1'b0;
        if (!reset && enable) begin
            if (cpu_req && (w_force || !vga_req)) begin
                w_cpu_gnt = 1'b1;
            end else if (vga_req) begin
                w_vga_gnt = 1'b1;
            end
        end
    end

    // Command register, owner pipeline and read-data holding registers.
    // The pipeline runs regardless of enable so in-flight reads complete.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_own_s1     <= OWN_NONE;
            r_vga_rvalid <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_vga_rdata  <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_mem_en <= w_vga_gnt | w_cpu_gnt;
            r_mem_we <= w_cpu_gnt & cpu_we;
            if (w_vga_gnt) begin
                r_mem_addr <= vga_addr;
            end else if (w_cpu_gnt) begin
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
            end

            if (w_vga_gnt) begin
                r_own_s1 <= OWN_VGA;
            end else if (w_cpu_gnt && !cpu_we) begin
                r_own_s1 <= OWN_CPU;
            end else begin
                r_own_s1 <= OWN_NONE;
            end

            r_vga_rvalid <= (r_own_s1 == OWN_VGA);
            r_cpu_rvalid <= (r_own_s1 == OWN_CPU);
            if (r_vga_rvalid) begin
                r_vga_rdata <= mem_rdata;
            end
            if (r_cpu_rvalid) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign vga_gnt    = w_vga_gnt;
    assign cpu_gnt    = w_cpu_gnt;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign vga_rvalid = r_vga_rvalid;
    assign cpu_rvalid = r_cpu_rvalid;
    // RAM data arrives in the rvalid cycle itself; otherwise hold the last word.
    assign vga_rdata  = r_vga_rvalid ? mem_rdata : r_vga_rdata;
    assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : r_cpu_rdata;

endmodule : vram_arbiter

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed vector bench for vram_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        ext_clk;
    logic        reset;
    logic        enable;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [15:0] vga_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:255];

    int errors;
    int checks;

    // ctl = {reset, enable, vga_req, cpu_req, cpu_we}
    // flg = {vga_gnt, cpu_gnt, mem_en, mem_we, vga_rvalid, cpu_rvalid}
    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] vaddr;
        logic [15:0] caddr;
        logic [15:0] cwdata;
        logic [5:0]  flg;
        logic [15:0] maddr;
        logic [15:0] mwdata;
        logic [15:0] vrd;
        logic [15:0] crd;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    vram_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .STARVE_MAX (8)
    ) dut (
        .ext_clk    (ext_clk),
        .reset      (reset),
        .enable     (enable),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial ext_clk = 1'b0;
    always #5 ext_clk = ~ext_clk;

    // Synchronous RAM; preloaded with A000+addr (0x0040 = BEEF) while reset is high.
    always @(posedge ext_clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) begin
                ram[a] <= 16'hA000 + 16'(a);
            end
            ram[8'h40] <= 16'hBEEF;
            mem_rdata  <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:0]] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    task automatic check(input string nm, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {reset, enable, vga_req, cpu_req, cpu_we} = v.ctl;
        vga_addr  = v.vaddr;
        cpu_addr  = v.caddr;
        cpu_wdata = v.cwdata;
    endtask

    initial begin
        logic [69:0] act;
        logic [69:0] exp;
        logic [1:0]  exp_gnt;
        int          cpu_grants;
        int          exp_cpu_grants;

        errors = 0;
        checks = 0;
        reset = 1'b1; enable = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // reset with both requesting
        vecs[0]  = '{5'b11110, 16'h0001, 16'h0002, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{5'b11110, 16'h0001, 16'h0002, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        // CPU read of 0x0040
        vecs[2]  = '{5'b01010, 16'h0000, 16'h0040, 16'h0000, 6'b010000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b001000, 16'h0040, 16'h0000, 16'h0000, 16'h0000};
        vecs[4]  = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b000001, 16'h0040, 16'h0000, 16'h0000, 16'hBEEF};
        // CPU write 0x0010 <- 0x1234, VGA read of 0x0010 next cycle
        vecs[5]  = '{5'b01011, 16'h0000, 16'h0010, 16'h1234, 6'b010000, 16'h0040, 16'h0000, 16'h0000, 16'hBEEF};
        vecs[6]  = '{5'b01100, 16'h0010, 16'h0000, 16'h0000, 6'b101100, 16'h0010, 16'h1234, 16'h0000, 16'hBEEF};
        vecs[7]  = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b001000, 16'h0010, 16'h1234, 16'h0000, 16'hBEEF};
        vecs[8]  = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b000010, 16'h0010, 16'h1234, 16'h1234, 16'hBEEF};
        vecs[9]  = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0010, 16'h1234, 16'h1234, 16'hBEEF};
        // VGA grant, then enable low two cycles with both requesting
        vecs[10] = '{5'b01110, 16'h0005, 16'h0006, 16'h0000, 6'b100000, 16'h0010, 16'h1234, 16'h1234, 16'hBEEF};
        vecs[11] = '{5'b00110, 16'h0005, 16'h0006, 16'h0000, 6'b001000, 16'h0005, 16'h1234, 16'h1234, 16'hBEEF};
        vecs[12] = '{5'b00110, 16'h0005, 16'h0006, 16'h0000, 6'b000010, 16'h0005, 16'h1234, 16'hA005, 16'hBEEF};
        vecs[13] = '{5'b01110, 16'h0007, 16'h0006, 16'h0000, 6'b100000, 16'h0005, 16'h1234, 16'hA005, 16'hBEEF};
        vecs[14] = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b001000, 16'h0007, 16'h1234, 16'hA005, 16'hBEEF};
        vecs[15] = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b000010, 16'h0007, 16'h1234, 16'hA007, 16'hBEEF};
        // CPU read grant, reset pulsed in the next cycle, VGA grant right after
        vecs[16] = '{5'b01010, 16'h0000, 16'h0040, 16'h0000, 6'b010000, 16'h0007, 16'h1234, 16'hA007, 16'hBEEF};
        vecs[17] = '{5'b11000, 16'h0000, 16'h0000, 16'h0000, 6'b001000, 16'h0040, 16'h0000, 16'hA007, 16'hBEEF};
        vecs[18] = '{5'b01100, 16'h0009, 16'h0000, 16'h0000, 6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[19] = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b001000, 16'h0009, 16'h0000, 16'h0000, 16'h0000};
        vecs[20] = '{5'b01000, 16'h0000, 16'h0000, 16'h0000, 6'b000010, 16'h0009, 16'h0000, 16'hA009, 16'h0000};

        repeat (2) @(posedge ext_clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            @(negedge ext_clk);
            act = {vga_gnt, cpu_gnt, mem_en, mem_we, vga_rvalid, cpu_rvalid,
                   mem_addr, mem_wdata, vga_rdata, cpu_rdata};
            exp = {vecs[i].flg, vecs[i].maddr, vecs[i].mwdata, vecs[i].vrd, vecs[i].crd};
            check($sformatf("vec%0d", i), act, exp);
            @(posedge ext_clk);
            #1;
        end

        // Continuous contention for 30 cycles
        cpu_grants = 0;
        exp_cpu_grants = 0;
        for (int k = 0; k < 30; k++) begin
            reset = 1'b0; enable = 1'b1;
            vga_req = 1'b1; vga_addr = 16'(k);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'(k + 64);
`ifdef VRAM_ARB_STARVE_EN
            exp_gnt = ((k % 9) == 8) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b10;
`endif
            if (exp_gnt == 2'b01) exp_cpu_grants++;
            @(negedge ext_clk);
            if (cpu_gnt) cpu_grants++;
            check($sformatf("contend%0d", k), 70'({vga_gnt, cpu_gnt}), 70'(exp_gnt));
            @(posedge ext_clk);
            #1;
        end
        check("contend_cpu_grants", 70'(cpu_grants), 70'(exp_cpu_grants));

        vga_req = 1'b0;
        cpu_req = 1'b0;
        repeat (3) @(posedge ext_clk);
        #1;
        @(negedge ext_clk);
        check("drain_idle", 70'({vga_gnt, cpu_gnt, mem_en, vga_rvalid, cpu_rvalid}), 70'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vram_arbiter

`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter sharing one synchronous 16-bit RAM between the VGA scan-out fetch and the CPU load/store port of `computer`. Grants at most one access per cycle, with fixed VGA priority and an optional CPU starvation guard. Registers the RAM command and routes read data back to the owning requester. Sits between the CPU memory-mapped video window, the VGA controller and the video RAM primitive.

## Interface
Parameters:
- `ADDR_W`, 16, address width (word-addressed)
- `DATA_W`, 16, data width
- `STARVE_MAX`, 8, maximum consecutive cycles the CPU may wait before a forced grant (legal range 1..255)

Ports:
- `ext_clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  arbitration enable; when low, no new grants are issued
- `vga_req`  in  1  VGA read request; held with `vga_addr` until granted
- `vga_addr`  in  ADDR_W  VGA read address
- `vga_gnt`  out  1  VGA request accepted this cycle
- `vga_rvalid`  out  1  `vga_rdata` valid
- `vga_rdata`  out  DATA_W  VGA read data
- `cpu_req`  in  1  CPU access request; held with address, `we` and data until granted
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_gnt`  out  1  CPU request accepted this cycle
- `cpu_rvalid`  out  1  `cpu_rdata` valid (reads only)
- `cpu_rdata`  out  DATA_W  CPU read data
- `mem_en`  out  1  RAM access strobe
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data; valid the cycle after `mem_en` with `mem_we` low

## Operation
- Grant decision each cycle is combinational from the request inputs and the registered state. `vga_gnt` and `cpu_gnt` are mutually exclusive, and both are forced low while `reset` is high or `enable` is low.
- Priority: VGA wins when both requesters are active. Exception: with the starvation guard compiled in and `cpu_wait == STARVE_MAX`, the CPU wins.
- Granted request is registered into `mem_en/mem_we/mem_addr/mem_wdata` on the same edge. The owner tag (NONE/VGA/CPU) is registered alongside it for reads only.
- Owner tag advances one stage. In the cycle after `mem_en` with read, the tagged owner's `*_rvalid` is high and its `*_rdata = mem_rdata`.
- Non-owner `rdata` holds its last value. Writes produce no rvalid.
- `cpu_wait` (8-bit counter):
  - increments when `cpu_req & ~cpu_gnt & enable`;
  - saturates at `STARVE_MAX`;
  - clears on `cpu_gnt` or when `cpu_req` is low.
- `enable` low: `cpu_wait` holds, and in-flight reads still complete and deliver rvalid.
- Reset values: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, both rvalid=0, both rdata=0, owner pipeline = NONE, `cpu_wait=0`.

## Timing
- Cycle T: req high and selected → gnt high in T. Requester drops or changes req/addr from T+1.
- Cycle T+1: `mem_en` with the registered command.
- Cycle T+2: rvalid/rdata to the owner. Read latency is 2 cycles from grant.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating owners are legal with no bubble.
- Both requesting continuously, guard on: VGA granted `STARVE_MAX` cycles, then the CPU 1 cycle, repeating.
- Reset asserted in T+1 after a read grant: owner pipeline cleared, no rvalid in T+2. The first grant is possible in the first cycle with `reset` low.
- Write in T followed by a read of the same address in T+1 returns the new data (RAM is read-after-write ordered by issue).

## Configuration
- `VRAM_ARB_STARVE_EN` defined: `cpu_wait` counter and forced CPU grant present as described.
- Not defined: counter removed and strict VGA priority applies. The CPU is granted only in cycles with `vga_req` low. `STARVE_MAX` is ignored.

## Structure
- Package `vram_arb_pkg`: owner enum `OWN_NONE/OWN_VGA/OWN_CPU`, default `ADDR_W`/`DATA_W` constants, and `STARVE_W = 8`.
- One sub-module, `vram_arb_starve`: the saturating wait counter plus the force-grant compare. It is instantiated only under `VRAM_ARB_STARVE_EN`.
- Remaining logic is top-level: grant mux, command register, owner pipeline, read-data steering.

## Test plan
1. **Reset with requests:** `reset` high 2 cycles with `vga_req=cpu_req=1` → both gnt=0, `mem_en=0`, both rvalid=0 throughout.
2. **CPU read:** RAM[0x0040]=0xBEEF, CPU read 0x0040 alone → `cpu_gnt` in T, `mem_en=1`/`mem_addr=0x0040` in T+1, `cpu_rvalid=1`/`cpu_rdata=0xBEEF` in T+2, `vga_rvalid=0`.
3. **Write then read:** CPU write 0x0010←0x1234, then VGA read 0x0010 next cycle → `vga_rdata=0x1234` two cycles after `vga_gnt`, with no `cpu_rvalid`.
4. **Contention, STARVE_MAX=8:** both requesting 30 cycles, macro defined → grants VGA×8, CPU×1, repeating. Macro undefined → `cpu_gnt` never asserted.
5. **Enable low:** `enable` dropped the cycle after a VGA read grant, both requesting → no new gnt while low, the pending `vga_rvalid` still fires, and grants resume on the first cycle `enable=1`.
6. **Reset mid-read:** `reset` pulsed in the cycle after a CPU read grant → `cpu_rvalid` stays 0 and `mem_en=0` the following cycle.
